pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised successor to the fixed PC+4 program-counter system.
- Holds the program counter and selects the next PC from sequential, branch, jump, jump-register and exception sources, with stall, halt/resume and a retired-instruction counter.
- Sits at the front of the mono-cycle MIPS datapath and feeds instruction memory; decode/ALU supply the control inputs.

Parameters:
- WIDTH, 32, PC width in bits; must be >= 28.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; truncated to WIDTH.
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception or address error.
- INC, 4, sequential increment.
- HOLD_CYCLES, 1, cycles PC is held at RESET_VECTOR after reset deasserts; must be >= 1.
- CNT_WIDTH, 32, width of the retired counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC this cycle (RUN state only)
- halt_req  input  1  request transition to HALTED
- resume  input  1  leave HALTED
- branch_taken  input  1  take conditional branch
- branch_offset  input  WIDTH  sign-extended word offset
- jump  input  1  J-type jump
- jump_index  input  26  J-type instruction index
- jr  input  1  jump register
- jr_target  input  WIDTH  register target
- exception  input  1  redirect to EXC_VECTOR
- pc  output  WIDTH  current PC (registered)
- pc_plus_inc  output  WIDTH  pc + INC (combinational, mod 2^WIDTH)
- state  output  2  00 HOLD, 01 RUN, 10 HALTED
- addr_err  output  1  one-cycle pulse on misaligned jr target
- retired  output  CNT_WIDTH  count of PC advances

Behaviour:
- Reset, while reset=1 at a clk edge:
  - pc=RESET_VECTOR, state=HOLD, hold counter=0, retired=0, addr_err=0.
  - Reset overrides all other inputs, including mid-halt, mid-stall and mid-exception.
- HOLD:
  - pc is held; all redirect inputs, including exception, are ignored.
  - The hold counter increments each cycle; after HOLD_CYCLES cycles with reset=0, state becomes RUN.
  - The first PC advance occurs on the edge after entering RUN.
- Next-PC selection in RUN, priority high to low:
  1. exception: EXC_VECTOR.
  2. jr: if jr_target[1:0]!=0, load EXC_VECTOR and pulse addr_err=1 for exactly that cycle's result; otherwise load jr_target.
  3. jump: {pc_plus_inc[WIDTH-1:28], jump_index, 2'b00}.
  4. branch_taken: pc_plus_inc + (branch_offset << 2), wrap mod 2^WIDTH.
  5. Otherwise: pc_plus_inc. PC wraps from all-ones region to low addresses with no flag.
- stall=1 in RUN: pc, retired and addr_err all hold/clear.
  - Exception still wins: it loads EXC_VECTOR even when stall=1.
- retired:
  - Increments by 1 on every edge where pc is loaded in RUN, including redirects.
  - Saturates at all-ones.
- halt_req in RUN with stall=0: that edge performs the normal PC update, then state=HALTED.
  - halt_req with stall=1: no update, and state still goes to HALTED.
- HALTED:
  - pc and retired hold.
  - resume=1: state=RUN on the next edge with no PC update on that edge.
  - exception=1: loads EXC_VECTOR, state=RUN, retired+1; exception beats resume.
  - halt_req is ignored.
- addr_err is registered, 1 only in the cycle after the offending edge, and 0 otherwise.
- Latency:
  - Control inputs are sampled at edge N; the new pc is visible after edge N.
  - pc_plus_inc follows pc combinationally.

Test Plan:
- Reset and sequencing: reset 2 cycles, HOLD_CYCLES=1 → pc=0 through HOLD, then 0,4,8,12 on successive edges; retired=3 after 3 advances; state 00→01.
- Branch and jump:
  - pc=0x100, branch_taken, offset=-4 (0xFFFFFFFC) → pc=0x0F4.
  - pc=0x100, jump, index=0x40 → pc=0x100.
  - jump and branch together → jump wins.
- jr: jr_target=0x2000 → pc=0x2000, addr_err=0. jr_target=0x2002 → pc=0x80000180, addr_err=1 for one cycle, retired+1.
- Stall and exception: stall 3 cycles at pc=0x20 → pc stays 0x20, retired unchanged. stall+exception → pc=0x80000180.
- Halt/resume:
  - halt_req at pc=0x40 → pc=0x44, state=10, held 5 cycles.
  - resume → state=01 with pc still 0x44, next edge pc=0x48.
  - exception while halted → 0x80000180, state=01.
- Wrap and reset mid-run:
  - WIDTH=32, pc=0xFFFFFFFC → next pc=0x00000000.
  - reset asserted at pc=0x80 during stall → pc=0, state=00, retired=0 on that edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS front end: post-reset hold, RUN/HALTED
// control, prioritised next-PC redirect, misaligned-jr trap and a saturating retired counter.
module pc_sequencer #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          INC          = 4,
  parameter int          HOLD_CYCLES  = 1,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 branch_taken,
  input  logic [WIDTH-1:0]     branch_offset,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  input  logic                 jr,
  input  logic [WIDTH-1:0]     jr_target,
  input  logic                 exception,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus_inc,
  output logic [1:0]           state,
  output logic                 addr_err,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [1:0] ST_HOLD   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  localparam int              HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
  // Jump keeps only the region bits above bit 27 of the incremented PC.
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(28'hFFF_FFFF);

  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [1:0]           state_q, state_d;
  logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                 addr_err_q, addr_err_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 advance;
  logic [WIDTH-1:0]     jump_tgt;
  logic [WIDTH-1:0]     branch_tgt;

  assign pc_plus_inc = pc_q + WIDTH'(INC);
  assign jump_tgt    = (pc_plus_inc & ~LOW_MASK) | WIDTH'({jump_index, 2'b00});
  assign branch_tgt  = pc_plus_inc + (branch_offset << 2);

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    addr_err_d = 1'b0;
    advance    = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
        else                         hold_cnt_d = hold_cnt_q + HCW'(1);
      end
      ST_RUN: begin
        // Exception is the only redirect that overrides a stall.
        if (exception) begin
          pc_d    = EXC_PC;
          advance = 1'b1;
        end else if (!stall) begin
          advance = 1'b1;
          if (jr) begin
            if (jr_target[1:0] != 2'b00) begin
              pc_d       = EXC_PC;
              addr_err_d = 1'b1;
            end else begin
              pc_d = jr_target;
            end
          end else if (jump) begin
            pc_d = jump_tgt;
          end else if (branch_taken) begin
            pc_d = branch_tgt;
          end else begin
            pc_d = pc_plus_inc;
          end
        end
        if (halt_req) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (exception) begin
          pc_d    = EXC_PC;
          advance = 1'b1;
          state_d = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_HOLD;
    endcase
    retired_d = (advance && !(&retired_q)) ? retired_q + CNT_WIDTH'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RST_PC;
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      addr_err_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      addr_err_q <= addr_err_d;
      retired_q  <= retired_d;
    end
  end

  assign pc       = pc_q;
  assign state    = state_q;
  assign addr_err = addr_err_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed steps queue hand-computed post-edge state,
// an independent monitor pops one entry per edge and compares against the DUT outputs.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall, halt_req, resume, branch_taken, jump, jr, exception;
  logic [31:0] branch_offset, jr_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus_inc, retired;
  logic [1:0]  state;
  logic        addr_err;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ppi;
    logic [1:0]  st;
    logic        ae;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .halt_req      (halt_req),
    .resume        (resume),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .exception     (exception),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
    .state         (state),
    .addr_err      (addr_err),
    .retired       (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    stall = 0; halt_req = 0; resume = 0; branch_taken = 0; jump = 0; jr = 0;
    exception = 0; branch_offset = '0; jr_target = '0; jump_index = '0;
  endtask

  // Inputs are already set by the caller; queue the expected state after the next edge.
  task automatic step(input string name, input logic [31:0] epc, input logic [1:0] est,
                      input logic eae, input logic [31:0] eret);
    exp_t e;
    e.name = name; e.pc = epc; e.ppi = epc + 32'd4; e.st = est; e.ae = eae; e.ret = eret;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    clr();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc !== e.pc || pc_plus_inc !== e.ppi || state !== e.st ||
            addr_err !== e.ae || retired !== e.ret) begin
          miscompares++;
          $display("FAIL %s: got pc=%h ppi=%h st=%b ae=%b ret=%0d, want pc=%h ppi=%h st=%b ae=%b ret=%0d",
                   e.name, pc, pc_plus_inc, state, addr_err, retired,
                   e.pc, e.ppi, e.st, e.ae, e.ret);
        end
      end
    end
  end

  initial begin : driver
    clr();
    reset = 1;
    step("rst0", 32'h0, 2'b00, 0, 0);
    reset = 1;
    step("rst1", 32'h0, 2'b00, 0, 0);
    reset = 0; exception = 1; jr = 1; jr_target = 32'h1000;
    step("hold_ignores_redirect", 32'h0, 2'b01, 0, 0);
    step("seq4", 32'h4, 2'b01, 0, 1);
    step("seq8", 32'h8, 2'b01, 0, 2);
    step("seq12", 32'hC, 2'b01, 0, 3);
    jr = 1; jr_target = 32'h100;
    step("jr_100", 32'h100, 2'b01, 0, 4);
    branch_taken = 1; branch_offset = 32'hFFFF_FFFC;
    step("branch_neg", 32'h0F4, 2'b01, 0, 5);
    jr = 1; jr_target = 32'h100;
    step("jr_100b", 32'h100, 2'b01, 0, 6);
    jump = 1; jump_index = 26'h40;
    step("jump_40", 32'h100, 2'b01, 0, 7);
    jump = 1; jump_index = 26'h80; branch_taken = 1; branch_offset = 32'h8;
    step("jump_beats_branch", 32'h200, 2'b01, 0, 8);
    jr = 1; jr_target = 32'h2000; jump = 1; jump_index = 26'h5;
    step("jr_beats_jump", 32'h2000, 2'b01, 0, 9);
    jr = 1; jr_target = 32'h2002;
    step("jr_misaligned", 32'h8000_0180, 2'b01, 1, 10);
    step("addr_err_clears", 32'h8000_0184, 2'b01, 0, 11);
    jr = 1; jr_target = 32'h20;
    step("jr_20", 32'h20, 2'b01, 0, 12);
    stall = 1;
    step("stall1", 32'h20, 2'b01, 0, 12);
    stall = 1; branch_taken = 1; branch_offset = 32'h10;
    step("stall2", 32'h20, 2'b01, 0, 12);
    stall = 1; jr = 1; jr_target = 32'h3;
    step("stall3_misaligned", 32'h20, 2'b01, 0, 12);
    stall = 1; exception = 1;
    step("stall_exception", 32'h8000_0180, 2'b01, 0, 13);
    jr = 1; jr_target = 32'h40;
    step("jr_40", 32'h40, 2'b01, 0, 14);
    halt_req = 1;
    step("halt", 32'h44, 2'b10, 0, 15);
    for (int i = 0; i < 5; i++) begin
      halt_req = 1; branch_taken = 1; branch_offset = 32'h4;
      step("halted_hold", 32'h44, 2'b10, 0, 15);
    end
    resume = 1;
    step("resume", 32'h44, 2'b01, 0, 15);
    step("after_resume", 32'h48, 2'b01, 0, 16);
    halt_req = 1; stall = 1;
    step("halt_with_stall", 32'h48, 2'b10, 0, 16);
    exception = 1; resume = 1;
    step("halted_exception", 32'h8000_0180, 2'b01, 0, 17);
    jr = 1; jr_target = 32'hFFFF_FFFC;
    step("jr_top", 32'hFFFF_FFFC, 2'b01, 0, 18);
    step("wrap", 32'h0, 2'b01, 0, 19);
    jr = 1; jr_target = 32'h80;
    step("jr_80", 32'h80, 2'b01, 0, 20);
    stall = 1;
    step("stall_80", 32'h80, 2'b01, 0, 20);
    stall = 1; exception = 1; reset = 1;
    step("reset_mid_stall", 32'h0, 2'b00, 0, 0);
    reset = 0;
    step("rehold", 32'h0, 2'b01, 0, 0);
    step("rerun4", 32'h4, 2'b01, 0, 1);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
